regfile_scoreboard: RTL

Parametrised multi-port register file for the pipelined datapath, the successor to the fixed 32x32 register file. It provides two combinational read ports and one write port with write-to-read bypass. It has an optional hardwired zero register and a self-sequenced initialisation engine that clears or index-loads every entry after reset. A per-entry pending scoreboard lets decode detect RAW hazards against in-flight writebacks.

---
 rtl/regfile_scoreboard.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Parametrised 2R/1W register file with write-to-read bypass, optional zero register,
// a post-reset initialisation sequencer and a per-entry pending (RAW hazard) scoreboard.
module regfile_scoreboard #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          INIT_INDEX = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_sel1,
    input  logic [ADDR_WIDTH-1:0] rd_sel2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_sel,
    output logic                  pend1,
    output logic                  pend2,
    output logic                  init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    busy_q;
    logic [DEPTH-1:0]        pend_q;
    logic [DEPTH-1:0]        pend_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    ready;
    logic                    wr_ok;
    logic                    issue_ok;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   init_val;

    assign ready     = (state_q == S_READY);
    assign init_busy = busy_q;

    // Writes to the hardwired zero entry are treated as if they never happened.
    assign wr_ok    = wr_en && ready && !(ZERO_REG && (wr_sel == '0));
    assign issue_ok = issue_en && ready;

    assign init_val = INIT_INDEX ? DATA_WIDTH'(cnt_q) : '0;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_sel;
        mem_wdata = wr_data;
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = init_val;
            end else begin
                mem_we    = wr_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Clear first, then set, so a same-cycle issue to the written entry stays pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_sel] = 1'b0;
        end
        if (issue_ok) begin
            pend_d[issue_sel] = 1'b1;
        end
        if (ZERO_REG) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            pend_q  <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= S_READY;
                        busy_q  <= 1'b0;
                    end
                end
                S_READY: begin
                    pend_q <= pend_d;
                end
                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rd_data1 = '0;
        pend1    = 1'b0;
        if (ready && !(ZERO_REG && (rd_sel1 == '0))) begin
            if (wr_ok && (wr_sel == rd_sel1)) begin
                rd_data1 = wr_data;
            end else begin
                rd_data1 = mem_q[rd_sel1];
                pend1    = pend_q[rd_sel1];
            end
        end
    end

    always_comb begin
        rd_data2 = '0;
        pend2    = 1'b0;
        if (ready && !(ZERO_REG && (rd_sel2 == '0))) begin
            if (wr_ok && (wr_sel == rd_sel2)) begin
                rd_data2 = wr_data;
            end else begin
                rd_data2 = mem_q[rd_sel2];
                pend2    = pend_q[rd_sel2];
            end
        end
    end

endmodule
